fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch controller sitting directly downstream of the 32-bit PC register. It consumes the registered PC and drives that register's enable and next value. It runs the instruction-memory request/ack handshake and delivers {pc, instr} into the IF/ID latch. It handles ID-stage stalls with a one-entry hold buffer, EX-stage redirects (flush), and memory timeouts.

Parameters:
PC_STEP, 4, sequential PC increment in bytes
MAX_WAIT, 15, cycles imem_req may stay high without imem_ack before the fetch error is raised (4-bit counter)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
pc_cur  in  32  current PC, from PC register d_out
pc_en  out  1  PC register write enable (combinational)
pc_next  out  32  PC register write data (combinational)
imem_req  out  1  fetch request (combinational from state)
imem_addr  out  32  fetch address, equals pc_cur
imem_ack  in  1  data valid this cycle; legal only while imem_req=1
imem_rdata  in  32  fetched instruction
stall_id  in  1  ID stage cannot accept; IF/ID must hold
redirect  in  1  branch/jump taken, flush fetch
redirect_pc  in  32  target PC
ifid_valid  out  1  IF/ID holds a live instruction
ifid_pc  out  32  PC of the IF/ID instruction
ifid_instr  out  32  IF/ID instruction word
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=1 at posedge): state=BOOT; ifid_valid=0; ifid_pc=0; ifid_instr=0; hold buffer empty; wait_cnt=0; fetch_err=0.
- While rst=1: pc_en=0 and imem_req=0.
- States:
  - BOOT: one idle cycle after reset release; no request. Go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc_cur. Request and address stay stable until ack, redirect or timeout.
  - HOLD: hold buffer full; imem_req=0.
  - ERR: imem_req=0, pc_en=0, fetch_err=1. Left only by rst.
- FETCH, imem_ack=1, no redirect: pc_en=1 and pc_next=pc_cur+PC_STEP (mod 2^32, wrap 0xFFFFFFFC->0x0) in the same cycle.
  - If stall_id=0 or ifid_valid=0: IF/ID loads {pc_cur, imem_rdata}, ifid_valid=1. Stay in FETCH. Throughput is 1 instruction/cycle with zero-wait memory.
  - Else: capture into hold buffer and go to HOLD.
- HOLD with stall_id=0: hold buffer moves to IF/ID; go to FETCH.
- IF/ID with stall_id=1 and ifid_valid=1: all ifid_* outputs hold unchanged.
- IF/ID with stall_id=0 and no new instruction: ifid_valid goes 0 next cycle (bubble); ifid_pc/ifid_instr hold.
- redirect=1 (any state except ERR and BOOT): highest priority, overrides stall_id and imem_ack.
  - pc_en=1, pc_next=redirect_pc.
  - Next cycle: ifid_valid=0, ifid_instr=0, hold buffer emptied, wait_cnt=0, state=FETCH.
  - An ack in the same cycle is discarded.
  - An outstanding request is withdrawn. The memory must accept withdrawal.
- wait_cnt increments each FETCH cycle with imem_req=1 and imem_ack=0, and clears on ack or redirect.
  - When wait_cnt reaches MAX_WAIT without ack: go to ERR next cycle.
  - ifid_valid holds its current value in ERR.
- pc_en=0 in every case not listed above. The PC changes only on ack or redirect.
- Reset mid-request: the request drops in the reset cycle; there is no partial IF/ID update.

Decomposition:
- Shared package:
  - state encoding (BOOT, FETCH, HOLD, ERR, 2 bits)
  - NOP_INSTR = 32'h0000_0000
  - PC_RESET = 32'h0, which must match the PC register reset value
- One natural sub-module: if_id_reg. This is the 64-bit IF/ID latch with valid, load, hold and flush. It reuses synchronous-reset, enable-gated register behaviour. The controller FSM, hold buffer and wait counter stay in fetch_ctrl.

Test Plan:
1. Reset then zero-wait memory (ack whenever req): BOOT 1 cycle, then imem_addr 0x0,0x4,0x8 on consecutive cycles. ifid_pc follows one cycle later with ifid_valid=1.
2. stall_id=1 for 3 cycles while ack arrives at pc 0x8: ifid holds pc 0x4. The 0x8 instruction is captured in the hold buffer, req=0, pc_cur=0xC stays frozen. After stall drops, ifid_pc=0x8 next cycle, then req resumes at 0xC.
3. redirect=1, redirect_pc=0x100, coinciding with ack at 0x10: pc_next=0x100, the ack data is dropped, ifid_valid=0 and ifid_instr=0 next cycle. The next fetch address is 0x100.
4. redirect during HOLD with stall_id=1: the hold buffer is flushed, ifid_valid=0 despite the stall, and the fetch restarts at the target.
5. Memory never acks: after MAX_WAIT=15 cycles, fetch_err=1, req=0, pc_en=0 permanently. rst clears fetch_err and re-enters BOOT.
6. pc_cur=0xFFFFFFFC with ack: pc_next=0x00000000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
package fetch_ctrl_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ERR   = 2'd3
   } fstate_t;

   // Word written into IF/ID on flush
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   // Must match the PC register reset value
   localparam logic [31:0] PC_RESET  = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if_id_reg.sv
// IF/ID pipeline latch: {pc, instr} plus valid, with load, hold, bubble and flush.
module if_id_reg
   import fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   // Flush beats load beats bubble; otherwise everything holds (stall)
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= 32'h0;
         instr <= 32'h0;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= pc_in;
         instr <= instr_in;
      end else if (bubble) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, runs the imem
// req/ack handshake, feeds IF/ID, and handles stall, redirect and timeout.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] PC_STEP  = 32'd4,
   parameter int          MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic        pc_en,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall_id,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        fetch_err
);

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   fstate_t     state;
   logic [3:0]  wait_cnt;
   logic [31:0] hold_pc;
   logic [31:0] hold_instr;

   logic in_fetch, in_hold, take_redir, take_ack;
   logic ld_fetch, ld_hold, ifid_load, ifid_bubble;
   logic [31:0] ld_pc, ld_instr;

   assign in_fetch   = !rst && (state == ST_FETCH);
   assign in_hold    = !rst && (state == ST_HOLD);
   // Redirect is honoured only once the controller is live (not BOOT/ERR)
   assign take_redir = (in_fetch || in_hold) && redirect;
   assign take_ack   = in_fetch && imem_ack && !redirect;

   assign imem_req  = in_fetch;
   assign imem_addr = pc_cur;
   assign pc_en     = take_redir || take_ack;
   assign pc_next   = redirect ? redirect_pc : pc_cur + PC_STEP;

   // New instruction goes straight to IF/ID unless a live instruction is stalled there
   assign ld_fetch    = take_ack && (!stall_id || !ifid_valid);
   assign ld_hold     = in_hold && !redirect && !stall_id;
   assign ifid_load   = ld_fetch || ld_hold;
   assign ld_pc       = ld_hold ? hold_pc    : pc_cur;
   assign ld_instr    = ld_hold ? hold_instr : imem_rdata;
   // ERR freezes IF/ID so the last valid instruction stays observable
   assign ifid_bubble = !stall_id && (state != ST_ERR);

   if_id_reg u_ifid (
      .clk      (clk),
      .rst      (rst),
      .flush    (take_redir),
      .load     (ifid_load),
      .bubble   (ifid_bubble),
      .pc_in    (ld_pc),
      .instr_in (ld_instr),
      .valid    (ifid_valid),
      .pc       (ifid_pc),
      .instr    (ifid_instr)
   );

   // Controller FSM, hold buffer, wait counter and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_BOOT;
         wait_cnt   <= 4'd0;
         hold_pc    <= 32'h0;
         hold_instr <= 32'h0;
         fetch_err  <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: state <= ST_FETCH;
            ST_FETCH: begin
               if (redirect) begin
                  wait_cnt <= 4'd0;
               end else if (imem_ack) begin
                  wait_cnt <= 4'd0;
                  if (stall_id && ifid_valid) begin
                     hold_pc    <= pc_cur;
                     hold_instr <= imem_rdata;
                     state      <= ST_HOLD;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
                  if (wait_cnt + 4'd1 == WAIT_LIM) begin
                     state     <= ST_ERR;
                     fetch_err <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  hold_pc    <= 32'h0;
                  hold_instr <= NOP_INSTR;
                  wait_cnt   <= 4'd0;
                  state      <= ST_FETCH;
               end else if (!stall_id) begin
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl with a PC register and memory around it,
// checked every cycle against a transaction-level reference model.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_cur;
   logic        pc_en;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall_id;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        fetch_err;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_ctrl dut (
      .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_en(pc_en), .pc_next(pc_next),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .stall_id(stall_id), .redirect(redirect),
      .redirect_pc(redirect_pc), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
      .ifid_instr(ifid_instr), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   // PC register the controller sits behind
   logic [31:0] pc_reg;
   always @(posedge clk) begin
      if (rst) pc_reg <= 32'h0;
      else if (pc_en) pc_reg <= pc_next;
   end
   assign pc_cur = pc_reg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: what the fetch unit should be doing, in plain terms
   bit          m_boot, m_err, m_v;
   logic [31:0] m_pc, m_ins;
   logic [63:0] m_hold[$];
   int          m_waits;

   function automatic bit m_fetching();
      return !m_boot && !m_err && (m_hold.size() == 0);
   endfunction

   task automatic model_reset();
      m_boot = 1; m_err = 0; m_v = 0; m_pc = 0; m_ins = 0; m_waits = 0;
      m_hold.delete();
   endtask

   // One clock: drive inputs, check outputs, advance the model across the edge
   task automatic step(input bit r, input bit a, input bit s, input bit rd,
                       input logic [31:0] rpc);
      bit          exp_req, exp_en, ack;
      logic [31:0] exp_next, pcc, rdata;
      rdata       = $urandom;
      exp_req     = !r && m_fetching();
      ack         = a && exp_req;
      rst         = r;
      stall_id    = s;
      redirect    = rd;
      redirect_pc = rpc;
      imem_rdata  = rdata;
      imem_ack    = ack;
      #2;
      pcc      = pc_cur;
      exp_en   = !r && !m_boot && !m_err && (rd || (m_fetching() && ack));
      exp_next = rd ? rpc : pcc + 32'd4;
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
      chk("ifid_pc", ifid_pc, m_pc);
      chk("ifid_instr", ifid_instr, m_ins);
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      chk("pc_en", {31'b0, pc_en}, {31'b0, exp_en});
      if (exp_en) chk("pc_next", pc_next, exp_next);
      if (exp_req) chk("imem_addr", imem_addr, pcc);
      // next-state of the model
      if (r) model_reset();
      else if (m_boot) m_boot = 0;
      else if (m_err) ;
      else if (rd) begin
         m_v = 0; m_ins = 0; m_waits = 0; m_hold.delete();
      end else if (m_hold.size() != 0) begin
         if (!s) begin
            {m_pc, m_ins} = m_hold.pop_front();
            m_v = 1;
         end
      end else if (ack) begin
         m_waits = 0;
         if (!s || !m_v) begin
            m_pc = pcc; m_ins = rdata; m_v = 1;
         end else m_hold.push_back({pcc, rdata});
      end else begin
         m_waits++;
         if (m_waits == 15) m_err = 1;
         if (!s) m_v = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_step(input int p_ack, input int p_stall, input int p_redir, input int p_rst);
      step($urandom_range(99) < p_rst, $urandom_range(99) < p_ack,
           $urandom_range(99) < p_stall, $urandom_range(99) < p_redir,
           {$urandom_range(32'h3FFF), 2'b00});
   endtask

   initial begin
      rst = 1; imem_ack = 0; imem_rdata = 0; stall_id = 0; redirect = 0; redirect_pc = 0;
      @(posedge clk);
      #1;
      model_reset();
      step(1, 0, 0, 0, 0);
      // zero-wait memory, no stalls
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
      // stall across an ack into the hold buffer, then release
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      // redirect coinciding with an ack
      step(0, 1, 0, 1, 32'h100);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      // redirect while holding under stall
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 1, 32'h200);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      // PC wrap at the top of the address space
      step(0, 0, 0, 1, 32'hFFFF_FFFC);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      // memory never answers: timeout, stuck in error, then reset recovers
      for (int i = 0; i < 22; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 32'h40);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) rand_step(60, 30, 8, 1);
      // slow memory to exercise timeouts under random traffic
      for (int i = 0; i < 1500; i++) rand_step(6, 30, 2, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
